// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// Signal prefixes are from the arbiter's point of view (i_ = into the arbiter).
interface alu_arbiter_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [31:0] i_req0_data_1;
  logic [31:0] i_req0_data_2;
  logic [3:0]  i_req0_mode;
  logic        o_rsp0_valid;
  logic        i_rsp0_ready;
  logic [31:0] o_rsp0_data;

  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [31:0] i_req1_data_1;
  logic [31:0] i_req1_data_2;
  logic [3:0]  i_req1_mode;
  logic        o_rsp1_valid;
  logic        i_rsp1_ready;
  logic [31:0] o_rsp1_data;

  logic [31:0] o_alu_data_1;
  logic [31:0] o_alu_data_2;
  logic [3:0]  o_alu_mode;
  logic [31:0] i_alu_data;

  modport slave (
    input  i_req0_valid, i_req0_data_1, i_req0_data_2, i_req0_mode, i_rsp0_ready,
    input  i_req1_valid, i_req1_data_1, i_req1_data_2, i_req1_mode, i_rsp1_ready,
    input  i_alu_data,
    output o_req0_ready, o_rsp0_valid, o_rsp0_data,
    output o_req1_ready, o_rsp1_valid, o_rsp1_data,
    output o_alu_data_1, o_alu_data_2, o_alu_mode
  );

  modport master (
    output i_req0_valid, i_req0_data_1, i_req0_data_2, i_req0_mode, i_rsp0_ready,
    output i_req1_valid, i_req1_data_1, i_req1_data_2, i_req1_mode, i_rsp1_ready,
    output i_alu_data,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_data,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_data,
    input  o_alu_data_1, o_alu_data_2, o_alu_mode
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: one op in flight,
// operands registered onto the ALU, result captured and returned per port.
module alu_arbiter #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_arbiter_if.slave bus,
  output logic         o_busy,
  output logic [1:0]   o_dbg_state
);

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds valid and payload stable until then, the receiver samples only on that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_last_grant;
  logic [31:0] r_result;
  logic [31:0] r_alu_data_1;
  logic [31:0] r_alu_data_2;
  logic [3:0]  r_alu_mode;

  logic        w_sel;
  logic        w_in_idle;
  logic        w_in_resp;
  logic        w_req_hs;
  logic        w_rsp_hs;
  logic        w_rsp0_valid;
  logic        w_rsp1_valid;

  // Winner selection; only meaningful while at least one port is valid.
  always_comb begin
    w_sel = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      w_sel = (FAIR_RR != 1'b0) ? ~r_last_grant : 1'b0;
    end else if (bus.i_req1_valid) begin
      w_sel = 1'b1;
    end
  end

  // Reset gates ready so it drops the instant reset asserts, not at the next edge.
  assign w_in_idle = i_rst_n && (r_state == S_IDLE);
  assign w_in_resp = (r_state == S_RESP);
  assign w_req_hs  = w_in_idle && (bus.i_req0_valid || bus.i_req1_valid);
  assign w_rsp_hs  = w_in_resp && (r_owner ? bus.i_rsp1_ready : bus.i_rsp0_ready);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_data_1 <= '0;
      r_alu_data_2 <= '0;
      r_alu_mode   <= '0;
    end else if (w_req_hs) begin
      r_owner      <= w_sel;
      r_last_grant <= w_sel;
      r_alu_data_1 <= w_sel ? bus.i_req1_data_1 : bus.i_req0_data_1;
      r_alu_data_2 <= w_sel ? bus.i_req1_data_2 : bus.i_req0_data_2;
      r_alu_mode   <= w_sel ? bus.i_req1_mode   : bus.i_req0_mode;
    end
  end

  // The ALU sees stable registered operands for the whole ISSUE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
    end else if (r_state == S_ISSUE) begin
      r_result <= bus.i_alu_data;
    end
  end

  assign w_rsp0_valid = w_in_resp && !r_owner;
  assign w_rsp1_valid = w_in_resp &&  r_owner;

  assign bus.o_req0_ready = w_in_idle && bus.i_req0_valid && !w_sel;
  assign bus.o_req1_ready = w_in_idle && bus.i_req1_valid &&  w_sel;
  assign bus.o_rsp0_valid = w_rsp0_valid;
  assign bus.o_rsp1_valid = w_rsp1_valid;
  assign bus.o_rsp0_data  = w_rsp0_valid ? r_result : '0;
  assign bus.o_rsp1_data  = w_rsp1_valid ? r_result : '0;
  assign bus.o_alu_data_1 = r_alu_data_1;
  assign bus.o_alu_data_2 = r_alu_data_2;
  assign bus.o_alu_mode   = r_alu_mode;

  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  a_single_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.o_req0_ready && bus.o_req1_ready));

  a_rsp0_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.o_rsp0_valid && !bus.i_rsp0_ready) |=> (bus.o_rsp0_valid && $stable(bus.o_rsp0_data)));

  a_rsp1_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.o_rsp1_valid && !bus.i_rsp1_ready) |=> (bus.o_rsp1_valid && $stable(bus.o_rsp1_data)));

  a_issue_to_resp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == S_ISSUE) |=> (r_state == S_RESP));

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational core ALU between two requesters: port 0 is the CPU execute stage, port 1 is the graphics/DMA helper.
- Each request carries two operands and a 4-bit ALU mode.
- The block arbitrates between requests, registers the winning operands onto the ALU inputs, captures the ALU result, and returns it through a valid/ready response channel.
- It sits between the requesters and the ALU instance. It does not decode the mode.

Parameters:
- FAIR_RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0_valid  in  1  port 0 request valid.
- o_req0_ready  out  1  port 0 request accepted this cycle.
- i_req0_data_1  in  32  port 0 operand 1.
- i_req0_data_2  in  32  port 0 operand 2.
- i_req0_mode  in  4  port 0 ALU mode.
- o_rsp0_valid  out  1  port 0 result valid.
- i_rsp0_ready  in  1  port 0 result consumed.
- o_rsp0_data  out  32  port 0 result.
- i_req1_valid, o_req1_ready, i_req1_data_1, i_req1_data_2, i_req1_mode, o_rsp1_valid, i_rsp1_ready, o_rsp1_data: same as port 0, for port 1.
- o_alu_data_1  out  32  operand 1 to the ALU.
- o_alu_data_2  out  32  operand 2 to the ALU.
- o_alu_mode  out  4  mode to the ALU.
- i_alu_data  in  32  combinational result from the ALU.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE; all o_* are 0; result register is 0; owner=0.
  - last_grant=1, so port 0 wins the first tie.
- States and transitions:
  - IDLE -> ISSUE on a request handshake.
  - ISSUE -> RESP unconditionally after 1 cycle.
  - RESP -> IDLE on a response handshake.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - o_reqN_ready is combinational: 1 only in IDLE, only for the selected port, and only when that port's i_reqN_valid=1.
  - The ready of the non-selected port is 0.
- Selection:
  - Only one port valid: that port wins.
  - Both valid, FAIR_RR=1: the port not equal to last_grant wins.
  - Both valid, FAIR_RR=0: port 0 wins.
- Request handshake (valid&ready at edge T):
  - Latch the winner's data_1, data_2 and mode into o_alu_data_1, o_alu_data_2 and o_alu_mode.
  - owner <= winner; last_grant <= winner.
- ISSUE (cycle T+1): at the end of the cycle, result register <= i_alu_data.
- RESP (from T+2):
  - o_rspN_valid=1 for N=owner; the other port's rsp_valid is 0.
  - o_rspN_data = result register for the owner.
  - The non-owner's rsp_data is 0.
- Response handshake: on o_rspN_valid & i_rspN_ready, go to IDLE with rsp_valid low next cycle.
- Latency and throughput:
  - Request handshake at edge T gives rsp_valid high from T+2. This is a fixed 2-cycle latency with no backpressure.
  - Maximum throughput is one op per 3 cycles.
- ALU operand outputs hold their last values outside ISSUE; they do not return to 0.
- The response is held stable (valid and data) for any number of cycles while i_rspN_ready=0. No new request is accepted meanwhile, and the other port stalls.
- Request protocol:
  - Requesters hold valid and payload stable until ready.
  - The arbiter samples the payload only on the handshake edge.
  - Payload changes before ready have no effect.
- Mode passthrough: mode is passed through unmodified, all 16 codes. Example codes: 0000 add, 0001 sub, 1110 and, 1011 arithmetic shift right.
- Reset mid-operation: the in-flight op is dropped. rsp_valid and ready drop immediately (asynchronous), and no response is issued after release.
- The result register is 32-bit, with no width change.

Test Plan:
1. Port 0 only, data_1=5, data_2=3, mode=0000, core ALU attached, rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2 with data=8; o_busy high T+1..T+2; port 1 outputs stay 0.
2. Port 1, data_1=5, data_2=3, mode=0001, rsp1_ready held 0 for 4 cycles -> rsp1_valid=1 and data=2 stable for those 4 cycles; a port 0 request during that time is not accepted; it is accepted in the first IDLE cycle after release.
3. FAIR_RR=1, both ports continuously valid for 6 ops (port 0 issues 0xF0F0F0F0 & 0xFF00FF00 mode 1110; port 1 issues 1<<4 mode 0010) -> grants alternate 0,1,0,1,0,1 starting with port 0; port 0 results are 0xF000F000, port 1 results are 0x00000010.
4. FAIR_RR=0, same stimulus -> all 6 grants go to port 0; port 1 starves; req1_ready is never 1.
5. i_rst_n pulled low during ISSUE of an op with data_1=0x80000000, data_2=4, mode=1011 -> outputs 0 asynchronously; after release there is no rsp_valid until a new request; the next tie goes to port 0.
6. Payload toggles while valid=1 before grant, final values 7 and 9 with mode 0000 at the handshake edge -> result is 16.
